// File: rtl/quad_step_decoder.sv
// Quadrature/index front end: synchronises and glitch-filters raw A/B/idx,
// decodes phase steps into one-cycle load/up/down strobes plus sel_mode, and flags illegal steps.
module quad_step_decoder #(
  parameter int unsigned FILT_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       idx_in,
  input  logic       err_clr,
  output logic       load,
  output logic       up,
  output logic       down,
  output logic [1:0] sel_mode,
  output logic       err
);

  typedef enum logic {SETTLE, RUN} state_t;

  // Channel bit order in the vectors below: [0]=A, [1]=B, [2]=idx
  logic [2:0] sync1, sync2, filt;
  logic [3:0] cnt [3];
  logic [1:0] prev_phase, phase;
  logic       prev_idx;
  logic [4:0] settle;
  state_t     state, next_state;
  logic       primed;

  logic       step_up, step_dn, illegal, idx_rise, issue;
  logic       load_d, up_d, down_d, err_d;
  logic [1:0] sel_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {idx_in, b_in, a_in};
      sync2 <= sync1;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == 4'(FILT_CYCLES - 1)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  // Priming: hold off decisions until the filters have had time to reach the
  // real input levels, so the reset-to-input jump is never seen as a step.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= SETTLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (state == SETTLE && settle == 5'(FILT_CYCLES + 2)) next_state = RUN;
  end

  always_comb begin
    primed = (state == RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              settle <= '0;
    else if (state == SETTLE) settle <= settle + 5'd1;
  end

  assign phase = {filt[0], filt[1]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_phase <= '0;
      prev_idx   <= 1'b0;
    end else begin
      prev_phase <= phase;
      prev_idx   <= filt[2];
    end
  end

  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    illegal = 1'b0;
    case ({prev_phase, phase})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_up = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_dn = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
      default: ;
    endcase
  end

  // Load outranks a coincident step; the step is dropped rather than deferred.
  always_comb begin
    idx_rise = filt[2] & ~prev_idx;
    issue    = primed & enable;
    load_d   = issue & idx_rise;
    up_d     = issue & step_up & ~idx_rise;
    down_d   = issue & step_dn & ~idx_rise;
    sel_d    = 2'b00;
    if (load_d)      sel_d = 2'b11;
    else if (up_d)   sel_d = 2'b01;
    else if (down_d) sel_d = 2'b10;
    err_d = err;
    if (primed && illegal) err_d = 1'b1;
    else if (err_clr)      err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      load     <= 1'b0;
      up       <= 1'b0;
      down     <= 1'b0;
      sel_mode <= 2'b00;
      err      <= 1'b0;
    end else begin
      load     <= load_d;
      up       <= up_d;
      down     <= down_d;
      sel_mode <= sel_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with FILT_CYCLES=3: strobe timing, glitch
// rejection, illegal-step flagging, index load priority, reset/priming and enable.
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       rstn, enable, a_in, b_in, idx_in, err_clr;
  logic       load, up, down, err;
  logic [1:0] sel_mode;

  int checks = 0;
  int failures = 0;
  int n_up = 0, n_down = 0, n_load = 0, n_multi = 0;

  quad_step_decoder #(.FILT_CYCLES(3)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .a_in(a_in), .b_in(b_in),
    .idx_in(idx_in), .err_clr(err_clr), .load(load), .up(up), .down(down),
    .sel_mode(sel_mode), .err(err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (up)   n_up   <= n_up + 1;
    if (down) n_down <= n_down + 1;
    if (load) n_load <= n_load + 1;
    if (int'(up) + int'(down) + int'(load) > 1) n_multi <= n_multi + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b1; a_in = 1'b0; b_in = 1'b0; idx_in = 1'b0; err_clr = 1'b0;
    tick(3);
    checks++;
    if ({load, up, down, sel_mode, err} !== 6'b0) begin
      failures++; $display("FAIL reset_outputs: got %b expected 000000", {load, up, down, sel_mode, err});
    end
    rstn = 1'b1;
    tick(12);
    checks++;
    if ({load, up, down, sel_mode, err} !== 6'b0) begin
      failures++; $display("FAIL post_release_idle: got %b expected 000000", {load, up, down, sel_mode, err});
    end
  endtask

  task automatic test_forward();
    logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    int u0 = n_up, d0 = n_down, l0 = n_load;
    for (int i = 0; i < 4; i++) begin
      {a_in, b_in} = seq[i];
      tick(5);
      checks++;
      if (up !== 1'b0) begin failures++; $display("FAIL fwd_early_%0d: got up=%b expected 0", i, up); end
      tick(1);
      checks++;
      if (up !== 1'b1 || sel_mode !== 2'b01) begin
        failures++; $display("FAIL fwd_pulse_%0d: got up=%b sel=%b expected up=1 sel=01", i, up, sel_mode);
      end
      tick(1);
      checks++;
      if (up !== 1'b0) begin failures++; $display("FAIL fwd_single_%0d: got up=%b expected 0", i, up); end
      tick(1);
    end
    checks++;
    if (n_up - u0 != 4 || n_down != d0 || n_load != l0 || err !== 1'b0) begin
      failures++;
      $display("FAIL fwd_totals: got up=%0d down=%0d load=%0d err=%b expected 4 0 0 0",
               n_up - u0, n_down - d0, n_load - l0, err);
    end
  endtask

  task automatic test_reverse();
    logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    int u0 = n_up, d0 = n_down;
    for (int i = 0; i < 4; i++) begin
      {a_in, b_in} = seq[i];
      tick(6);
      checks++;
      if (down !== 1'b1 || sel_mode !== 2'b10) begin
        failures++; $display("FAIL rev_pulse_%0d: got down=%b sel=%b expected down=1 sel=10", i, down, sel_mode);
      end
      tick(2);
    end
    checks++;
    if (n_down - d0 != 4 || n_up != u0) begin
      failures++; $display("FAIL rev_totals: got down=%0d up=%0d expected 4 0", n_down - d0, n_up - u0);
    end
  endtask

  // A is the high phase bit, so A rising from 00 is a reverse step and A falling back is forward.
  task automatic test_glitch();
    int u0 = n_up, d0 = n_down;
    a_in = 1'b1; tick(2); a_in = 1'b0;
    tick(15);
    checks++;
    if (n_up != u0 || n_down != d0) begin
      failures++; $display("FAIL glitch_2cyc: got up=%0d down=%0d expected 0 0", n_up - u0, n_down - d0);
    end
    a_in = 1'b1; tick(3); a_in = 1'b0;
    tick(20);
    checks++;
    if (n_down - d0 != 1 || n_up - u0 != 1) begin
      failures++; $display("FAIL glitch_3cyc: got down=%0d up=%0d expected 1 1", n_down - d0, n_up - u0);
    end
  endtask

  task automatic test_illegal();
    int u0 = n_up, d0 = n_down;
    {a_in, b_in} = 2'b11;
    tick(10);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL illegal_set: got err=%b expected 1", err); end
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_clr: got err=%b expected 0", err); end
    {a_in, b_in} = 2'b00;
    tick(10);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL illegal_reset_back: got err=%b expected 1", err); end
    {a_in, b_in} = 2'b11;
    tick(5);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL set_beats_clr: got err=%b expected 1", err); end
    tick(4);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    checks++;
    if (err !== 1'b0 || n_up != u0 || n_down != d0) begin
      failures++;
      $display("FAIL illegal_no_step: got err=%b up=%0d down=%0d expected 0 0 0", err, n_up - u0, n_down - d0);
    end
  endtask

  task automatic test_index();
    int l0 = n_load, u0;
    idx_in = 1'b1;
    tick(6);
    checks++;
    if (load !== 1'b1 || sel_mode !== 2'b11) begin
      failures++; $display("FAIL idx_pulse: got load=%b sel=%b expected load=1 sel=11", load, sel_mode);
    end
    tick(14);
    checks++;
    if (n_load - l0 != 1) begin failures++; $display("FAIL idx_held_once: got loads=%0d expected 1", n_load - l0); end
    idx_in = 1'b0;
    tick(10);
    l0 = n_load; u0 = n_up;
    idx_in = 1'b1; b_in = 1'b0;
    tick(6);
    checks++;
    if (load !== 1'b1 || up !== 1'b0 || sel_mode !== 2'b11) begin
      failures++; $display("FAIL idx_with_step: got load=%b up=%b sel=%b expected 1 0 11", load, up, sel_mode);
    end
    tick(15);
    checks++;
    if (n_up != u0 || n_load - l0 != 1) begin
      failures++; $display("FAIL idx_step_consumed: got up=%0d load=%0d expected 0 1", n_up - u0, n_load - l0);
    end
    idx_in = 1'b0;
    tick(10);
  endtask

  task automatic test_reset_priming();
    int u0, d0, l0;
    a_in = 1'b0;
    tick(6);
    checks++;
    if (up !== 1'b1) begin failures++; $display("FAIL pre_reset_up: got up=%b expected 1", up); end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({load, up, down, sel_mode, err} !== 6'b0) begin
      failures++; $display("FAIL async_reset: got %b expected 000000", {load, up, down, sel_mode, err});
    end
    {a_in, b_in} = 2'b11;
    tick(3);
    u0 = n_up; d0 = n_down; l0 = n_load;
    rstn = 1'b1;
    tick(14);
    checks++;
    if (n_up != u0 || n_down != d0 || n_load != l0 || err !== 1'b0) begin
      failures++;
      $display("FAIL priming_quiet: got up=%0d down=%0d load=%0d err=%b expected 0 0 0 0",
               n_up - u0, n_down - d0, n_load - l0, err);
    end
    b_in = 1'b0;
    tick(10);
    checks++;
    if (n_up - u0 != 1 || n_down != d0) begin
      failures++; $display("FAIL primed_step: got up=%0d down=%0d expected 1 0", n_up - u0, n_down - d0);
    end
    u0 = n_up; d0 = n_down;
    enable = 1'b0;
    a_in = 1'b0; tick(8);
    b_in = 1'b1; tick(8);
    checks++;
    if (n_up != u0 || n_down != d0) begin
      failures++; $display("FAIL disabled_steps: got up=%0d down=%0d expected 0 0", n_up - u0, n_down - d0);
    end
    enable = 1'b1;
    tick(5);
    checks++;
    if (n_up != u0 || n_down != d0) begin
      failures++; $display("FAIL no_stale_steps: got up=%0d down=%0d expected 0 0", n_up - u0, n_down - d0);
    end
    a_in = 1'b1;
    tick(10);
    checks++;
    if (n_up - u0 != 1 || n_down != d0) begin
      failures++; $display("FAIL reenabled_step: got up=%0d down=%0d expected 1 0", n_up - u0, n_down - d0);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_illegal();
    test_index();
    test_reset_priming();
    checks++;
    if (n_multi != 0) begin failures++; $display("FAIL one_hot_strobes: got %0d overlaps expected 0", n_multi); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
